// File: rtl/packet_rx_parser_if.sv
// Framed receive stream from the radio interface into the packet parser.
// A word transfers on a rising clk edge where rx_valid && rx_ready; the source holds
// rx_data/rx_sop/rx_eop stable while rx_valid is high and rx_ready is low.
interface packet_rx_parser_if #(
    parameter int WORD_WIDTH = 16
);
    logic                  rx_valid;
    logic                  rx_sop;
    logic                  rx_eop;
    logic [WORD_WIDTH-1:0] rx_data;
    logic                  rx_ready;

    modport master (output rx_valid, rx_sop, rx_eop, rx_data, input rx_ready);
    modport slave  (input rx_valid, rx_sop, rx_eop, rx_data, output rx_ready);
endinterface

// File: rtl/packet_rx_parser.sv
// Receive-side header parser: captures type/src/dest/hops/CH/timeslot from framed words,
// strobes the fields for one cycle per good frame, and counts discarded frames.
module packet_rx_parser #(
    parameter int WORD_WIDTH = 16,
    parameter int MAX_LEN    = 32,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  nrst,
    packet_rx_parser_if.slave     rx,
    output logic [2:0]            fPacketType,
    output logic [WORD_WIDTH-1:0] fSourceID,
    output logic [WORD_WIDTH-1:0] destinationID,
    output logic [WORD_WIDTH-1:0] fHopsFromCH,
    output logic [WORD_WIDTH-1:0] fChosenCH,
    output logic [WORD_WIDTH-1:0] fTimeslot,
    output logic                  pkt_valid,
    output logic [7:0]            drop_count,
    output logic [2:0]            dbg_state
);
    localparam int CW = $clog2(MAX_LEN + 1);
    localparam int IW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_HDR      = 3'd1,
        S_PAYLOAD  = 3'd2,
        S_DONE     = 3'd3,
        S_DROP     = 3'd4,
        S_DROP_CNT = 3'd5
    } state_t;

    state_t                state, next_state;
    logic                  ready_q, ready_d;
    logic                  drop_inc;
    logic [CW-1:0]         word_cnt, cnt_inc;
    logic [IW-1:0]         idle_cnt;
    logic [2:0]            sh_type;
    logic [WORD_WIDTH-1:0] sh_src, sh_dest, sh_hops, sh_ch, sh_ts;
    logic                  take, timeout_hit;

    assign rx.rx_ready   = ready_q;
    assign take          = rx.rx_valid && ready_q;
    assign cnt_inc       = word_cnt + CW'(1);
    assign timeout_hit   = !take && (idle_cnt == IW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= S_IDLE;
            ready_q <= 1'b0;
        end else begin
            state   <= next_state;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        next_state = state;
        drop_inc   = 1'b0;
        case (state)
            S_IDLE: begin
                if (take && rx.rx_sop) begin
                    if (rx.rx_eop) drop_inc = 1'b1;
                    else           next_state = S_HDR;
                end
            end
            S_HDR, S_PAYLOAD: begin
                if (take) begin
                    if (rx.rx_sop) begin
                        // Restart: the interrupted frame is a drop; a sop+eop restart is also short.
                        drop_inc   = 1'b1;
                        next_state = rx.rx_eop ? S_DROP_CNT : S_HDR;
                    end else if (state == S_HDR) begin
                        if (word_cnt == CW'(5)) next_state = rx.rx_eop ? S_DONE : S_PAYLOAD;
                        else if (rx.rx_eop)     next_state = S_DROP_CNT;
                    end else if (rx.rx_eop) begin
                        next_state = S_DONE;
                    end else if (cnt_inc == CW'(MAX_LEN)) begin
                        drop_inc   = 1'b1;
                        next_state = S_DROP;
                    end
                end else if (timeout_hit) begin
                    drop_inc   = 1'b1;
                    next_state = S_IDLE;
                end
            end
            S_DONE: next_state = S_IDLE;
            S_DROP: begin
                if ((take && rx.rx_eop) || timeout_hit) next_state = S_IDLE;
            end
            S_DROP_CNT: begin
                drop_inc   = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Ready is registered so it is low during reset and during the DONE/DROP_CNT bubbles.
    always_comb begin
        ready_d   = !(next_state == S_DONE || next_state == S_DROP_CNT);
        dbg_state = state;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            word_cnt <= '0;
            idle_cnt <= '0;
            sh_type  <= '0;
            sh_src   <= '0;
            sh_dest  <= '0;
            sh_hops  <= '0;
            sh_ch    <= '0;
            sh_ts    <= '0;
        end else begin
            if (take) begin
                if (rx.rx_sop && (state == S_IDLE || state == S_HDR || state == S_PAYLOAD)) begin
                    sh_type  <= rx.rx_data[2:0];
                    word_cnt <= CW'(1);
                end else if (state == S_HDR) begin
                    case (word_cnt)
                        CW'(1):  sh_src  <= rx.rx_data;
                        CW'(2):  sh_dest <= rx.rx_data;
                        CW'(3):  sh_hops <= rx.rx_data;
                        CW'(4):  sh_ch   <= rx.rx_data;
                        CW'(5):  sh_ts   <= rx.rx_data;
                        default: ;
                    endcase
                    word_cnt <= cnt_inc;
                end else if (state == S_PAYLOAD) begin
                    word_cnt <= cnt_inc;
                end
            end
            if (take || !(state == S_HDR || state == S_PAYLOAD || state == S_DROP))
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            fPacketType   <= 3'b111;
            fSourceID     <= '0;
            destinationID <= '0;
            fHopsFromCH   <= '0;
            fChosenCH     <= '0;
            fTimeslot     <= '0;
            pkt_valid     <= 1'b0;
            drop_count    <= '0;
        end else begin
            pkt_valid <= (state == S_DONE);
            if (state == S_DONE) begin
                fPacketType   <= sh_type;
                fSourceID     <= sh_src;
                destinationID <= sh_dest;
                fHopsFromCH   <= sh_hops;
                fChosenCH     <= sh_ch;
                fTimeslot     <= sh_ts;
            end else begin
                fPacketType <= 3'b111;
            end
            if (drop_inc && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_packet_rx_parser.sv
// Directed bench for packet_rx_parser: a table of frames with hand-computed outcomes,
// followed by hand-written timeout, restart, saturation and mid-frame reset sequences.
module tb_packet_rx_parser;
    typedef struct {
        logic [2:0]  typ;
        int          len;
        logic [15:0] src, dest, hops, ch, ts;
        bit          exp_pkt;
        int          drop_inc;
    } vec_t;

    logic        clk;
    logic        nrst;
    logic [2:0]  fPacketType;
    logic [15:0] fSourceID, destinationID, fHopsFromCH, fChosenCH, fTimeslot;
    logic        pkt_valid;
    logic [7:0]  drop_count;
    logic [2:0]  dbg_state;

    int n_cmp = 0;
    int n_fail = 0;
    int pkt_seen = 0;
    int stall_cycles = 0;
    int exp_drop = 0;
    vec_t last_good;
    vec_t vecs[10];

    packet_rx_parser_if #(.WORD_WIDTH(16)) bus();

    packet_rx_parser dut (
        .clk          (clk),
        .nrst         (nrst),
        .rx           (bus),
        .fPacketType  (fPacketType),
        .fSourceID    (fSourceID),
        .destinationID(destinationID),
        .fHopsFromCH  (fHopsFromCH),
        .fChosenCH    (fChosenCH),
        .fTimeslot    (fTimeslot),
        .pkt_valid    (pkt_valid),
        .drop_count   (drop_count),
        .dbg_state    (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) if (pkt_valid) pkt_seen++;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, expected finish before 200000ns");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] typ, input int len, input logic [15:0] src,
                                input logic [15:0] dest, input logic [15:0] hops,
                                input logic [15:0] ch, input logic [15:0] ts,
                                input bit exp_pkt, input int drop_inc);
        vec_t v;
        v.typ = typ; v.len = len; v.src = src; v.dest = dest; v.hops = hops;
        v.ch = ch; v.ts = ts; v.exp_pkt = exp_pkt; v.drop_inc = drop_inc;
        return v;
    endfunction

    function automatic logic [15:0] word_of(input vec_t v, input int i);
        case (i)
            0:       return {13'h1A5, v.typ};
            1:       return v.src;
            2:       return v.dest;
            3:       return v.hops;
            4:       return v.ch;
            5:       return v.ts;
            default: return 16'hD000 + 16'(i);
        endcase
    endfunction

    // Called at a negedge; returns at the negedge following the edge that took the word.
    task automatic send_word(input logic [15:0] d, input logic s, input logic e);
        int guard = 0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = d;
        bus.rx_sop   = s;
        bus.rx_eop   = e;
        while (!bus.rx_ready && guard < 20) begin
            @(negedge clk);
            guard++;
            stall_cycles++;
        end
        if (guard >= 20) check("ready_wait", 32'(bus.rx_ready), 32'd1);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_sop   = 1'b0;
        bus.rx_eop   = 1'b0;
    endtask

    task automatic send_frame(input vec_t v, input int stop_at);
        for (int i = 0; i < v.len && i < stop_at; i++)
            send_word(word_of(v, i), i == 0, i == v.len - 1);
    endtask

    task automatic check_fields(input string tag, input vec_t v);
        check({tag, "_src"},  32'(fSourceID),     32'(v.src));
        check({tag, "_dest"}, 32'(destinationID), 32'(v.dest));
        check({tag, "_hops"}, 32'(fHopsFromCH),   32'(v.hops));
        check({tag, "_ch"},   32'(fChosenCH),     32'(v.ch));
        check({tag, "_ts"},   32'(fTimeslot),     32'(v.ts));
    endtask

    task automatic apply_vec(input vec_t v);
        int p0 = pkt_seen;
        int s0 = stall_cycles;
        send_frame(v, v.len);
        if (v.exp_pkt) begin
            check("ready_done", 32'(bus.rx_ready), 32'd0);
            @(negedge clk);
            check("strobe", 32'(pkt_valid), 32'd1);
            check("type", 32'(fPacketType), 32'(v.typ));
            check_fields("pkt", v);
            @(negedge clk);
            check("strobe_end", 32'(pkt_valid), 32'd0);
            check("type_idle", 32'(fPacketType), 32'd7);
            last_good = v;
        end else begin
            repeat (3) @(negedge clk);
            check("type_nopkt", 32'(fPacketType), 32'd7);
            check_fields("hold", last_good);
        end
        repeat (2) @(negedge clk);
        exp_drop = exp_drop + v.drop_inc;
        check("drop_count", 32'(drop_count), 32'(exp_drop));
        check("pkt_count", 32'(pkt_seen - p0), v.exp_pkt ? 32'd1 : 32'd0);
        check("no_stall", 32'(stall_cycles - s0), 32'd0);
    endtask

    initial begin
        vecs[0] = mk(3'd2, 6,  16'd7,      16'd3,      16'd2,      16'd9,      16'd4,      1, 0);
        vecs[1] = mk(3'd5, 10, 16'h0011,   16'h0003,   16'd1,      16'h0022,   16'd6,      1, 0);
        vecs[2] = mk(3'd1, 4,  16'hAAAA,   16'hBBBB,   16'hCCCC,   16'hDDDD,   16'hEEEE,   0, 1);
        vecs[3] = mk(3'd3, 40, 16'h1111,   16'h2222,   16'h3333,   16'h4444,   16'h5555,   0, 1);
        vecs[4] = mk(3'd4, 32, 16'h0101,   16'h0202,   16'h0303,   16'h0404,   16'h0505,   1, 0);
        vecs[5] = mk(3'd6, 7,  16'hFFFF,   16'h8000,   16'h0001,   16'h7FFF,   16'h1234,   1, 0);
        vecs[6] = mk(3'd7, 1,  16'h0,      16'h0,      16'h0,      16'h0,      16'h0,      0, 1);
        vecs[7] = mk(3'd0, 33, 16'h9999,   16'h8888,   16'h7777,   16'h6666,   16'h5555,   0, 1);
        vecs[8] = mk(3'd0, 6,  16'h00A0,   16'h00B0,   16'h00C0,   16'h00D0,   16'h00E0,   1, 0);
        vecs[9] = mk(3'd2, 5,  16'h0F0F,   16'hF0F0,   16'h0FF0,   16'hF00F,   16'h00FF,   0, 1);

        last_good    = mk(3'd7, 0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0);
        nrst         = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_sop   = 1'b0;
        bus.rx_eop   = 1'b0;
        bus.rx_data  = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.rx_ready), 32'd0);
        check("rst_type",  32'(fPacketType),  32'd7);
        check("rst_valid", 32'(pkt_valid),    32'd0);
        check("rst_drop",  32'(drop_count),   32'd0);
        check("rst_state", 32'(dbg_state),    32'd0);
        check_fields("rst", last_good);
        nrst = 1'b1;
        repeat (2) @(negedge clk);
        check("ready_after_rst", 32'(bus.rx_ready), 32'd1);

        for (int k = 0; k < 10; k++) apply_vec(vecs[k]);

        // Stall after W2 long enough to hit the idle timeout.
        send_frame(vecs[1], 3);
        repeat (62) @(negedge clk);
        check("timeout_early", 32'(drop_count), 32'(exp_drop));
        repeat (4) @(negedge clk);
        exp_drop++;
        check("timeout_drop", 32'(drop_count), 32'(exp_drop));
        check("timeout_idle", 32'(dbg_state), 32'd0);
        check("timeout_nopkt", 32'(fPacketType), 32'd7);

        // New sop after W3 of a frame aborts it and parses the new frame.
        send_frame(vecs[4], 4);
        exp_drop++;
        apply_vec(vecs[5]);

        // Back-to-back short frames drive drop_count into saturation.
        for (int i = 0; i < 300; i++) send_word(16'h0001, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        exp_drop = (exp_drop + 300 > 255) ? 255 : exp_drop + 300;
        check("drop_sat", 32'(drop_count), 32'(exp_drop));
        send_word(16'h0001, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        check("drop_no_wrap", 32'(drop_count), 32'(exp_drop));

        // Asynchronous reset in the middle of the header.
        send_frame(vecs[1], 2);
        nrst = 1'b0;
        #1;
        last_good = mk(3'd7, 0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0);
        check("mrst_ready", 32'(bus.rx_ready), 32'd0);
        check("mrst_type",  32'(fPacketType),  32'd7);
        check("mrst_valid", 32'(pkt_valid),    32'd0);
        check("mrst_drop",  32'(drop_count),   32'd0);
        check("mrst_state", 32'(dbg_state),    32'd0);
        check_fields("mrst", last_good);
        @(negedge clk);
        nrst = 1'b1;
        exp_drop = 0;
        repeat (2) @(negedge clk);
        apply_vec(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
